// File: rtl/bram_word_port_if.sv
// Request/response handshake plus dual byte-wide RAM port bundle for bram_word_port.
// The master side is the core and RAM environment; the slave side is the adapter.
interface bram_word_port_if #(
  parameter int BYTE_ADDR_WIDTH = 12
);
  logic                       req_valid;
  logic                       req_ready;
  logic [BYTE_ADDR_WIDTH-1:0] req_addr;
  logic                       req_we;
  logic [1:0]                 req_size;
  logic                       req_unsigned;
  logic [31:0]                req_wdata;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [31:0]                rsp_rdata;
  logic                       rsp_err;
  logic [BYTE_ADDR_WIDTH-1:0] mem_addr_a;
  logic [BYTE_ADDR_WIDTH-1:0] mem_addr_b;
  logic                       mem_read_a;
  logic                       mem_read_b;
  logic                       mem_we_a;
  logic                       mem_we_b;
  logic [7:0]                 mem_wdata_a;
  logic [7:0]                 mem_wdata_b;
  logic [7:0]                 mem_rdata_a;
  logic [7:0]                 mem_rdata_b;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
           mem_rdata_a, mem_rdata_b,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr_a, mem_addr_b, mem_read_a, mem_read_b, mem_we_a, mem_we_b,
           mem_wdata_a, mem_wdata_b
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
           mem_rdata_a, mem_rdata_b,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr_a, mem_addr_b, mem_read_a, mem_read_b, mem_we_a, mem_we_b,
           mem_wdata_a, mem_wdata_b
  );
endinterface

// File: rtl/bram_word_port.sv
// 32-bit load/store adapter onto a byte-wide dual-port BRAM, two bytes per cycle,
// little-endian, with alignment checking and load sign/zero extension.
module bram_word_port #(
  parameter int BYTE_ADDR_WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  bram_word_port_if.slave  bus
);
  localparam int AW = BYTE_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAPT, RESP} state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic          w_accept;
  logic          w_bad;

  function automatic logic [31:0] extend(input logic [15:0] d, input logic half, input logic uns);
    if (half) return uns ? {16'h0, d} : {{16{d[15]}}, d};
    return uns ? {24'h0, d[7:0]} : {{24{d[7]}}, d[7:0]};
  endfunction

  assign w_accept = bus.req_valid && (r_state == IDLE);
  assign w_bad    = (bus.req_size == 2'b11) ||
                    ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  // Request fields only matter while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= bus.req_addr;
      r_we    <= bus.req_we;
      r_size  <= bus.req_size;
      r_uns   <= bus.req_unsigned;
      r_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_rdata <= 32'h0;
          r_err   <= w_bad;
          r_state <= w_bad ? RESP : ACC0;
        end
        ACC0: r_state <= (r_size == 2'b10) ? ACC1 : (r_we ? RESP : CAPT);
        ACC1: begin
          if (!r_we) r_rdata[15:0] <= {bus.mem_rdata_b, bus.mem_rdata_a};
          r_state <= r_we ? RESP : CAPT;
        end
        // r_rdata[15:0] holds bytes 0/1 of a word load captured during ACC1.
        CAPT: begin
          if (r_size == 2'b10)
            r_rdata <= {bus.mem_rdata_b, bus.mem_rdata_a, r_rdata[15:0]};
          else
            r_rdata <= extend({bus.mem_rdata_b, bus.mem_rdata_a}, r_size[0], r_uns);
          r_state <= RESP;
        end
        RESP: if (bus.rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM side is a pure decode of state and latched request, so reset drops it at once.
  always_comb begin
    bus.mem_addr_a  = '0;
    bus.mem_addr_b  = '0;
    bus.mem_read_a  = 1'b0;
    bus.mem_read_b  = 1'b0;
    bus.mem_we_a    = 1'b0;
    bus.mem_we_b    = 1'b0;
    bus.mem_wdata_a = 8'h0;
    bus.mem_wdata_b = 8'h0;
    if (r_state == ACC0) begin
      bus.mem_addr_a  = r_addr;
      bus.mem_we_a    = r_we;
      bus.mem_read_a  = !r_we;
      bus.mem_wdata_a = r_we ? r_wdata[7:0] : 8'h0;
      if (r_size != 2'b00) begin
        bus.mem_addr_b  = r_addr + AW'(1);
        bus.mem_we_b    = r_we;
        bus.mem_read_b  = !r_we;
        bus.mem_wdata_b = r_we ? r_wdata[15:8] : 8'h0;
      end
    end else if (r_state == ACC1) begin
      bus.mem_addr_a  = r_addr + AW'(2);
      bus.mem_addr_b  = r_addr + AW'(3);
      bus.mem_we_a    = r_we;
      bus.mem_we_b    = r_we;
      bus.mem_read_a  = !r_we;
      bus.mem_read_b  = !r_we;
      bus.mem_wdata_a = r_we ? r_wdata[23:16] : 8'h0;
      bus.mem_wdata_b = r_we ? r_wdata[31:24] : 8'h0;
    end
  end
endmodule
